// File: rtl/rr_arb8_2x.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arb8_2x : 8-way round-robin arbiter driving dec3x8_2x A2..A0 / EN,     |
// |              one-cycle EN-low gap between grants.                        |
// | Optional hold timeout enabled by macro ARB_HOLD_TIMEOUT_EN.              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_arb8_2x #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic [7:0] REQ,
  input  logic       DONE,
  output logic       A0,
  output logic       A1,
  output logic       A2,
  output logic       EN,
  output logic       TMO
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] idx;
  logic       en;
  logic       tmo;
  logic [2:0] winner;
  logic       any_req;
  logic       timeout;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range_check
    $error("rr_arb8_2x: HOLD_MAX must be within 1..255");
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  logic [7:0] hold_cnt;

  // Counter holds the number of completed GRANT cycles minus one at each edge.
  assign timeout = (hold_cnt == 8'(HOLD_MAX - 1));

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      hold_cnt <= 8'd0;
    end else if (state != ST_GRANT) begin
      hold_cnt <= 8'd0;
    end else begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // First requester found scanning upward from ptr, wrapping mod 8.
  always_comb begin
    any_req = 1'b0;
    winner  = ptr;
    for (int k = 0; k < 8; k++) begin
      if (!any_req && REQ[ptr + 3'(k)]) begin
        any_req = 1'b1;
        winner  = ptr + 3'(k);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state <= ST_IDLE;
      ptr   <= 3'd0;
      idx   <= 3'd0;
      en    <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      tmo <= 1'b0;
      case (state)
        ST_IDLE, ST_GAP: begin
          if (any_req) begin
            idx   <= winner;
            en    <= 1'b1;
            state <= ST_GRANT;
          end else begin
            en    <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (DONE || !REQ[idx] || timeout) begin
            en    <= 1'b0;
            ptr   <= idx + 3'd1;
            state <= ST_GAP;
            tmo   <= !DONE && REQ[idx] && timeout;
          end
        end
        default: begin
          en    <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign A0  = idx[0];
  assign A1  = idx[1];
  assign A2  = idx[2];
  assign EN  = en;
  assign TMO = tmo;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb8_2x.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rr_arb8_2x : scoreboard bench for rr_arb8_2x against an ownership      |
// |                 model of the arbitration rules.                          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rr_arb8_2x;

  localparam int HOLD = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk  = 1'b0;
  logic       rstb = 1'b0;
  logic       done = 1'b0;
  logic [7:0] req  = 8'h00;
  logic       a0, a1, a2, en, tmo;

  rr_arb8_2x #(.HOLD_MAX(HOLD)) dut (
    .CLK  (clk),
    .RSTB (rstb),
    .REQ  (req),
    .DONE (done),
    .A0   (a0),
    .A1   (a1),
    .A2   (a2),
    .EN   (en),
    .TMO  (tmo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       tmo;
    logic       en;
    logic [2:0] addr;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  // Model: who owns the select (-1 = nobody), where the next scan starts,
  // how many cycles the current owner has held it.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_addr  = 0;
  int m_held  = 0;
  bit m_tmo   = 1'b0;

  task automatic model_edge();
    if (!rstb) begin
      m_owner = -1; m_ptr = 0; m_addr = 0; m_held = 0; m_tmo = 1'b0;
    end else if (m_owner >= 0) begin
      m_held++;
      m_tmo = 1'b0;
      if (done || !req[m_owner] || (TIMEOUT_ON && m_held >= HOLD)) begin
        m_tmo   = !done && req[m_owner];
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end
    end else begin
      m_tmo = 1'b0;
      for (int k = 0; k < 8; k++)
        if (m_owner < 0 && req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
      if (m_owner >= 0) begin
        m_addr = m_owner;
        m_held = 0;
      end
    end
    sb.push_back({m_tmo, (m_owner >= 0), 3'(m_addr)});
  endtask

  task automatic step(input bit r, input logic [7:0] q, input bit d);
    @(negedge clk);
    rstb = r;
    req  = q;
    done = d;
    model_edge();
  endtask

  // Monitor: the DUT presents outputs every cycle; compare against queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compared++;
        if ({tmo, en, a2, a1, a0} !== e) begin
          mismatched++;
          $display("FAIL out cyc %0d: got tmo=%b en=%b idx=%0d, expected tmo=%b en=%b idx=%0d",
                   cyc, tmo, en, {a2, a1, a0}, e.tmo, e.en, e.addr);
        end
      end
    end
  end

  initial begin
    logic [7:0] r;
    bit         d;
    bit         rs;

    repeat (3) step(1'b0, 8'hFF, 1'b0);
    repeat (2) step(1'b1, 8'h00, 1'b0);

    repeat (3) step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h20, 1'b1);
    repeat (3) step(1'b1, 8'h00, 1'b0);

    for (int i = 0; i < 30; i++) step(1'b1, 8'hFF, (m_owner >= 0 && m_held >= 1));
    repeat (2) step(1'b1, 8'h00, 1'b0);

    repeat (110) step(1'b1, 8'h0C, 1'b0);
    repeat (3) step(1'b1, 8'h00, 1'b0);

    repeat (3) step(1'b1, 8'h08, 1'b0);
    repeat (3) step(1'b1, 8'h02, 1'b0);
    repeat (2) step(1'b1, 8'h00, 1'b0);

    repeat (3) step(1'b1, 8'h40, 1'b0);
    step(1'b0, 8'h40, 1'b0);
    repeat (4) step(1'b1, 8'h81, 1'b0);

    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      d  = ($urandom_range(3) == 0);
      rs = ($urandom_range(99) != 0);
      step(rs, r, d);
    end
    repeat (3) step(1'b1, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
